// File: rtl/q3_rr_reg_arbiter.sv
// q3_rr_reg_arbiter
// Round-robin arbiter and write sequencer for one shared DW-bit register.
// Exactly one requester is selected per transaction. Its write data is
// captured into the shared register, a one-cycle acknowledge is returned,
// and then the rotate pointer moves to the requester after the winner.
//
// Optional build macro:
//   ARB_PRIO0_EN  requester 0 has fixed absolute priority. Requesters
//                 1..NREQ-1 rotate among themselves.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req        [NREQ] per-requester level request
//   wdata      [NREQ*DW] packed write data; requester i uses wdata[i*DW +: DW]
//   gnt        [NREQ] one-hot grant, high while requester i owns the register
//   ack        [NREQ] one-hot, one-cycle write-complete pulse
//   q          [DW] shared register contents
//   last_src   [IW] index of the last requester whose write completed
//   busy       high in any state other than IDLE
//   dbg_state  [2] current FSM state (0=IDLE, 1=CAPT, 2=ACK)
//
// Handshake: a requester raises req[i] and holds it with stable wdata.
// gnt[i] rises one cycle after req is sampled in IDLE. If req[i] is still
// high at the next edge, the write happens and ack[i] pulses for one cycle.
// The requester drops req[i] during that ack cycle. If req[i] is dropped
// while gnt[i] is high, the transaction is abandoned without an ack.
module q3_rr_reg_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DW-1:0]         wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            ack,
    output logic [DW-1:0]              q,
    output logic [$clog2(NREQ)-1:0]    last_src,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      sel, sel_n;
    logic [IW-1:0]      ptr, ptr_n;
    logic [NREQ-1:0]    gnt_n, ack_n;
    logic [DW-1:0]      q_n;
    logic [IW-1:0]      last_n;
    logic               busy_n;

    logic [IW-1:0]      pick;
    logic [IW:0]        idx;
    logic [DW-1:0]      sel_data;
    logic               sel_req;

    assign dbg_state = state;

    // Rotation scan. The loop runs from the farthest position back toward
    // ptr, so the last match it records is the nearest set bit at or after
    // ptr (with wrap).
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
`ifdef ARB_PRIO0_EN
            if (idx != '0 && req[idx[IW-1:0]]) begin
                pick = idx[IW-1:0];
            end
`else
            if (req[idx[IW-1:0]]) begin
                pick = idx[IW-1:0];
            end
`endif
        end
`ifdef ARB_PRIO0_EN
        // Requester 0 overrides the rotation whenever it asks.
        if (req[0]) begin
            pick = '0;
        end
`endif
    end

    // Mux out the granted requester's data and request bit.
    always_comb begin
        sel_data = '0;
        sel_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                sel_data = wdata[i*DW +: DW];
                sel_req  = req[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        gnt_n   = gnt;
        ack_n   = '0;
        q_n     = q;
        last_n  = last_src;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    sel_n   = pick;
                    gnt_n   = ONE_HOT0 << pick;
                    state_n = CAPT;
                end
            end
            CAPT: begin
                gnt_n = '0;
                if (sel_req) begin
                    q_n     = sel_data;
                    ack_n   = ONE_HOT0 << sel;
                    last_n  = sel;
                    ptr_n   = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
                    state_n = ACK;
                end else begin
                    // Withdrawal: the pointer stays put, so this requester
                    // keeps its place in the rotation.
                    state_n = IDLE;
                end
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= '0;
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            last_src <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            gnt      <= gnt_n;
            ack      <= ack_n;
            q        <= q_n;
            last_src <= last_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_q3_rr_reg_arbiter.sv
// Testbench for q3_rr_reg_arbiter: directed scenarios with a scoreboard.
// Expected write completions are queued by the driver as {src, data}. A
// negedge monitor pops one entry per observed ack and compares ack, q and
// last_src against it.
module tb_q3_rr_reg_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;
    localparam int W    = IW + DW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   wdata = '0;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        q;
    logic [IW-1:0]        last_src;
    logic                 busy;
    logic [1:0]           dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [NREQ-1:0] mon_ack;

    q3_rr_reg_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .q         (q),
        .last_src  (last_src),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        wdata = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        wdata[i*DW +: DW] = v;
    endtask

    task automatic expect_write(input int src, input logic [DW-1:0] d);
        exp_q.push_back({IW'(src), d});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && ack !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: ack=%b q=%h last_src=%0d", ack, q, last_src);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_ack = NREQ'(1) << mon_e[W-1:DW];
                if (ack !== mon_ack || q !== mon_e[DW-1:0] || last_src !== mon_e[W-1:DW]) begin
                    n_err++;
                    $display("FAIL write_check: ack=%b q=%h last_src=%0d expected ack=%b q=%h last_src=%0d",
                             ack, q, last_src, mon_ack, mon_e[DW-1:0], mon_e[W-1:DW]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int order[5];
    logic [DW-1:0] lane_val[4];

    initial begin
        lane_val[0] = 8'h11; lane_val[1] = 8'h22; lane_val[2] = 8'h33; lane_val[3] = 8'h44;
`ifdef ARB_PRIO0_EN
        order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0; order[4] = 0;
`else
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
`endif

        // Reset state while reset is held low.
        #12;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_last_src", 32'(last_src), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle: no requests for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_ack", 32'(ack), 0);
            chk("idle_q", 32'(q), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // Single write from requester 2.
        do_reset();
        set_lane(2, 8'hA5);
        req = 4'b0100;
        expect_write(2, 8'hA5);
        step();
        chk("s2_gnt", 32'(gnt), 32'h4);
        chk("s2_busy_capt", 32'(busy), 1);
        step();
        chk("s2_ack", 32'(ack), 32'h4);
        chk("s2_q", 32'(q), 32'hA5);
        chk("s2_last_src", 32'(last_src), 2);
        chk("s2_gnt_off", 32'(gnt), 0);
        req = 4'b0000;
        step();
        chk("s2_busy_done", 32'(busy), 0);
        chk("s2_ack_off", 32'(ack), 0);

        // All four requesting continuously from ptr=0.
        do_reset();
        for (int i = 0; i < 4; i++) set_lane(i, lane_val[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) expect_write(order[k], lane_val[order[k]]);
        for (int t = 1; t <= 14; t++) begin
            step();
            if (t % 3 == 1) chk("s3_gnt_order", 32'(gnt), 32'(4'b0001 << order[t / 3]));
        end
        req = 4'b0000;
        step();
        chk("s3_busy_done", 32'(busy), 0);
        chk("s3_last_src", 32'(last_src), 32'(order[4]));

        // Withdrawal in CAPT, then 0011 must start at requester 0.
        do_reset();
        set_lane(0, 8'h3C);
        set_lane(1, 8'h5A);
        req = 4'b0010;
        step();
        chk("s4_gnt1", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        chk("s4_abort_gnt", 32'(gnt), 0);
        chk("s4_abort_ack", 32'(ack), 0);
        chk("s4_abort_q", 32'(q), 0);
        chk("s4_abort_busy", 32'(busy), 0);
        req = 4'b0011;
        expect_write(0, 8'h3C);
        expect_write(1, 8'h5A);
        step();
        chk("s4_gnt0_first", 32'(gnt), 32'h1);
        step();
        req = 4'b0010;
        step();
        step();
        chk("s4_gnt1_next", 32'(gnt), 32'h2);
        step();
        chk("s4_q_final", 32'(q), 32'h5A);
        req = 4'b0000;
        step();

        // Asynchronous reset during CAPT.
        do_reset();
        set_lane(3, 8'hFF);
        req = 4'b1000;
        step();
        chk("s5_gnt3", 32'(gnt), 32'h8);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_async_gnt", 32'(gnt), 0);
        chk("s5_async_q", 32'(q), 0);
        chk("s5_async_busy", 32'(busy), 0);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) step();
        chk("s5_q_after", 32'(q), 0);
        chk("s5_busy_after", 32'(busy), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
